// File: rtl/enemy_fleet.sv
// Purpose : N_ENEMY-slot enemy manager (spawn/fall/explode per slot) plus a 3-stage pixel lookup for the VGA compositor.
// Latency : slot state/pulses update on the edge that samples move_tick/hit_valid; pixel x/y -> rgb/enemy_en/pix_slot is 3 cycles.
// Backpressure: none; the pixel pipeline accepts a new coordinate every cycle and the slots never stall.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_move_tick, i_spawn_en movement strobe and spawn permission
//   i_hit_valid, i_hit_idx  hit report from collision logic
//   i_x, i_y, i_sprite_rgb  pixel coordinate in, synchronous sprite ROM data in
//   o_sprite_addr           registered ROM address (col + row*SPR_W)
//   o_rgb, o_enemy_en,
//   o_pix_slot              registered pixel colour / coverage / owning slot
//   o_enemy_x, o_enemy_y    flattened slot positions, slot i at [10i+9:10i]
//   o_active_mask,
//   o_alive_count           slots in ACTIVE / slots in ACTIVE or BOOM
//   o_kill_pulse,
//   o_escape_pulse          one-cycle event pulses
module enemy_fleet #(
    parameter int          N_ENEMY    = 4,
    parameter int          SCR_W      = 640,
    parameter int          SCR_H      = 480,
    parameter int          SPR_W      = 50,
    parameter int          SPR_H      = 50,
    parameter int          SPEED      = 1,
    parameter int          BOOM_TICKS = 32,
    parameter logic [11:0] BOOM_RGB   = 12'h969,
    parameter logic [9:0]  LFSR_SEED  = 10'h2A5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_move_tick,
    input  logic                   i_spawn_en,
    input  logic                   i_hit_valid,
    input  logic [2:0]             i_hit_idx,
    input  logic [9:0]             i_x,
    input  logic [9:0]             i_y,
    input  logic [11:0]            i_sprite_rgb,
    output logic [11:0]            o_sprite_addr,
    output logic [11:0]            o_rgb,
    output logic                   o_enemy_en,
    output logic [2:0]             o_pix_slot,
    output logic [10*N_ENEMY-1:0]  o_enemy_x,
    output logic [10*N_ENEMY-1:0]  o_enemy_y,
    output logic [N_ENEMY-1:0]     o_active_mask,
    output logic [3:0]             o_alive_count,
    output logic                   o_kill_pulse,
    output logic                   o_escape_pulse
);

    localparam int XR   = SCR_W - SPR_W;
    localparam int YLIM = SCR_H - SPR_H;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_BOOM} state_t;

    state_t      r_state [N_ENEMY];
    state_t      w_state_nxt [N_ENEMY];
    logic [9:0]  r_ex [N_ENEMY];
    logic [9:0]  w_ex_nxt [N_ENEMY];
    logic [9:0]  r_ey [N_ENEMY];
    logic [9:0]  w_ey_nxt [N_ENEMY];
    logic [7:0]  r_cnt [N_ENEMY];
    logic [7:0]  w_cnt_nxt [N_ENEMY];

    logic [9:0]  r_lfsr;
    logic [9:0]  w_spawn_x;
    logic        w_spawn_done;
    logic        w_kill;
    logic        w_escape;
    logic        r_kill_pulse;
    logic        r_escape_pulse;
    logic [3:0]  w_alive;

    // Pixel pipeline
    logic        w_cov;
    logic        w_boom;
    logic [2:0]  w_slot;
    logic [11:0] w_addr;
    logic [11:0] w_rgb;
    logic [11:0] r_s1_addr;
    logic        r_s1_cov;
    logic        r_s1_boom;
    logic [2:0]  r_s1_slot;
    logic        r_s2_cov;
    logic        r_s2_boom;
    logic [2:0]  r_s2_slot;
    logic [11:0] r_rgb;
    logic        r_enemy_en;
    logic [2:0]  r_pix_slot;

    // Fold the LFSR into the legal x range with one subtraction (max 1023-590 < 590).
    assign w_spawn_x = (r_lfsr >= 10'(XR)) ? (r_lfsr - 10'(XR)) : r_lfsr;

    // Slot next-state: a hit on an ACTIVE slot beats a same-cycle tick,
    // and only the first IDLE slot in index order claims a spawn.
    always_comb begin
        w_spawn_done = 1'b0;
        w_kill       = 1'b0;
        w_escape     = 1'b0;
        for (int i = 0; i < N_ENEMY; i++) begin
            w_state_nxt[i] = r_state[i];
            w_ex_nxt[i]    = r_ex[i];
            w_ey_nxt[i]    = r_ey[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (i_move_tick && i_spawn_en && !w_spawn_done) begin
                        w_spawn_done   = 1'b1;
                        w_state_nxt[i] = ST_ACTIVE;
                        w_ex_nxt[i]    = w_spawn_x;
                        w_ey_nxt[i]    = 10'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (i_hit_valid && (i_hit_idx == 3'(i))) begin
                        w_state_nxt[i] = ST_BOOM;
                        w_cnt_nxt[i]   = 8'(BOOM_TICKS);
                    end else if (i_move_tick) begin
                        if (({1'b0, r_ey[i]} + 11'(SPEED)) >= 11'(YLIM)) begin
                            w_state_nxt[i] = ST_IDLE;
                            w_escape       = 1'b1;
                        end else begin
                            w_ey_nxt[i] = r_ey[i] + 10'(SPEED);
                        end
                    end
                end
                ST_BOOM: begin
                    if (i_move_tick) begin
                        if (r_cnt[i] <= 8'd1) begin
                            w_state_nxt[i] = ST_IDLE;
                            w_cnt_nxt[i]   = 8'd0;
                            w_kill         = 1'b1;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - 8'd1;
                        end
                    end
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                r_state[i] <= ST_IDLE;
                r_ex[i]    <= 10'd0;
                r_ey[i]    <= 10'd0;
                r_cnt[i]   <= 8'd0;
            end
            r_lfsr         <= LFSR_SEED;
            r_kill_pulse   <= 1'b0;
            r_escape_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_ex[i]    <= w_ex_nxt[i];
                r_ey[i]    <= w_ey_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            // x^10 + x^7 + 1 Fibonacci; a non-zero seed never reaches zero.
            r_lfsr         <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
            r_kill_pulse   <= w_kill;
            r_escape_pulse <= w_escape;
        end
    end

    // Stage 1 lookup: scan from the top index down so the lowest index wins.
    always_comb begin
        w_cov  = 1'b0;
        w_boom = 1'b0;
        w_slot = 3'd0;
        w_addr = 12'd0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if ((r_state[i] != ST_IDLE) &&
                ({1'b0, i_x} >= {1'b0, r_ex[i]}) &&
                ({1'b0, i_x} <  ({1'b0, r_ex[i]} + 11'(SPR_W))) &&
                ({1'b0, i_y} >= {1'b0, r_ey[i]}) &&
                ({1'b0, i_y} <  ({1'b0, r_ey[i]} + 11'(SPR_H)))) begin
                w_cov  = 1'b1;
                w_boom = (r_state[i] == ST_BOOM);
                w_slot = 3'(i);
                w_addr = 12'(i_x - r_ex[i]) + (12'(i_y - r_ey[i]) * 12'(SPR_W));
            end
        end
    end

    assign w_rgb = r_s2_boom ? BOOM_RGB : i_sprite_rgb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_addr  <= 12'd0;
            r_s1_cov   <= 1'b0;
            r_s1_boom  <= 1'b0;
            r_s1_slot  <= 3'd0;
            r_s2_cov   <= 1'b0;
            r_s2_boom  <= 1'b0;
            r_s2_slot  <= 3'd0;
            r_rgb      <= 12'hFFF;
            r_enemy_en <= 1'b0;
            r_pix_slot <= 3'd0;
        end else begin
            r_s1_addr <= w_addr;
            r_s1_cov  <= w_cov;
            r_s1_boom <= w_boom;
            r_s1_slot <= w_slot;
            // Tags wait one cycle while the ROM turns the address into data.
            r_s2_cov  <= r_s1_cov;
            r_s2_boom <= r_s1_boom;
            r_s2_slot <= r_s1_slot;
            if (r_s2_cov) begin
                r_rgb      <= w_rgb;
                r_enemy_en <= (w_rgb != 12'hFFF);
                r_pix_slot <= r_s2_slot;
            end else begin
                r_rgb      <= 12'hFFF;
                r_enemy_en <= 1'b0;
                r_pix_slot <= 3'd0;
            end
        end
    end

    always_comb begin
        w_alive = 4'd0;
        for (int i = 0; i < N_ENEMY; i++) begin
            w_alive = w_alive + {3'b000, (r_state[i] != ST_IDLE)};
        end
    end

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_flat
        assign o_enemy_x[10*g +: 10] = r_ex[g];
        assign o_enemy_y[10*g +: 10] = r_ey[g];
        assign o_active_mask[g]      = (r_state[g] == ST_ACTIVE);
    end

    assign o_alive_count  = w_alive;
    assign o_kill_pulse   = r_kill_pulse;
    assign o_escape_pulse = r_escape_pulse;
    assign o_sprite_addr  = r_s1_addr;
    assign o_rgb          = r_rgb;
    assign o_enemy_en     = r_enemy_en;
    assign o_pix_slot     = r_pix_slot;

endmodule

// File: tb/tb_enemy_fleet.sv
// Purpose : self-checking bench for enemy_fleet (table vectors, directed corner sequences, random stimulus vs reference model).
// Latency : compares slot outputs one edge after stimulus, pixel outputs three edges after the coordinate.
// Backpressure: none; a synchronous ROM model answers every address one cycle later.
module tb_enemy_fleet;

    localparam int N  = 4;
    localparam int BT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        move_tick = 1'b0;
    logic        spawn_en = 1'b0;
    logic        hit_valid = 1'b0;
    logic [2:0]  hit_idx = 3'd0;
    logic [9:0]  px = 10'd0;
    logic [9:0]  py = 10'd0;
    logic [11:0] sprite_rgb = 12'd0;
    logic [11:0] sprite_addr;
    logic [11:0] rgb;
    logic        enemy_en;
    logic [2:0]  pix_slot;
    logic [10*N-1:0] enemy_x;
    logic [10*N-1:0] enemy_y;
    logic [N-1:0] active_mask;
    logic [3:0]  alive_count;
    logic        kill_pulse;
    logic        escape_pulse;

    enemy_fleet dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_move_tick(move_tick), .i_spawn_en(spawn_en),
        .i_hit_valid(hit_valid), .i_hit_idx(hit_idx), .i_x(px), .i_y(py),
        .i_sprite_rgb(sprite_rgb), .o_sprite_addr(sprite_addr), .o_rgb(rgb),
        .o_enemy_en(enemy_en), .o_pix_slot(pix_slot), .o_enemy_x(enemy_x),
        .o_enemy_y(enemy_y), .o_active_mask(active_mask), .o_alive_count(alive_count),
        .o_kill_pulse(kill_pulse), .o_escape_pulse(escape_pulse)
    );

    initial forever #5 clk = ~clk;

    function automatic int rom_f(input int a);
        return (a % 5 == 3) ? 'hFFF : (((a * 7) ^ 'h0F0) & 'hFFF);
    endfunction

    always @(posedge clk) sprite_rgb <= 12'(rom_f(int'(sprite_addr)));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = active, 2 = exploding
    int m_st[N];
    int m_x[N];
    int m_y[N];
    int m_cnt[N];
    int m_lfsr;
    int m_kill;
    int m_esc;

    typedef struct { int cov; int boom; int slot; int addr; } pix_t;
    pix_t pq[$];

    function automatic int fold_x(input int r);
        return (r >= 590) ? r - 590 : r;
    endfunction

    function automatic pix_t pix_model(input int x, input int y);
        pix_t p;
        p.cov = 0; p.boom = 0; p.slot = 0; p.addr = 0;
        for (int i = 0; i < N; i++) begin
            if (p.cov == 0 && m_st[i] != 0 && x >= m_x[i] && x < m_x[i] + 50 &&
                y >= m_y[i] && y < m_y[i] + 50) begin
                p.cov  = 1;
                p.boom = (m_st[i] == 2) ? 1 : 0;
                p.slot = i;
                p.addr = (x - m_x[i]) + (y - m_y[i]) * 50;
            end
        end
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_cnt[i] = 0;
        end
        m_lfsr = 'h2A5; m_kill = 0; m_esc = 0;
        pq.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"}, int'(sprite_addr), 0);
        chk({tag, "_rgb"}, int'(rgb), 'hFFF);
        chk({tag, "_en"}, int'(enemy_en), 0);
        chk({tag, "_slot"}, int'(pix_slot), 0);
        chk({tag, "_ex"}, (enemy_x == '0) ? 1 : 0, 1);
        chk({tag, "_ey"}, (enemy_y == '0) ? 1 : 0, 1);
        chk({tag, "_mask"}, int'(active_mask), 0);
        chk({tag, "_alive"}, int'(alive_count), 0);
        chk({tag, "_kill"}, int'(kill_pulse), 0);
        chk({tag, "_esc"}, int'(escape_pulse), 0);
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
    task automatic step(input int tk, input int sp, input int hv, input int hi, input int x, input int y);
        int spawned;
        int emask;
        int ealive;
        pix_t p;
        move_tick = tk[0]; spawn_en = sp[0]; hit_valid = hv[0]; hit_idx = hi[2:0];
        px = 10'(x); py = 10'(y);
        pq.push_back(pix_model(x & 1023, y & 1023));
        @(posedge clk);
        m_kill = 0; m_esc = 0; spawned = 0;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 1 && hv != 0 && hi == i) begin
                m_st[i] = 2; m_cnt[i] = BT;
            end else if (tk != 0) begin
                if (m_st[i] == 1) begin
                    if (m_y[i] + 1 >= 430) begin m_st[i] = 0; m_esc = 1; end
                    else m_y[i] = m_y[i] + 1;
                end else if (m_st[i] == 2) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) begin m_st[i] = 0; m_kill = 1; end
                end else if (sp != 0 && spawned == 0) begin
                    spawned = 1; m_st[i] = 1; m_x[i] = fold_x(m_lfsr); m_y[i] = 0;
                end
            end
        end
        m_lfsr = ((m_lfsr << 1) & 1023) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
        @(negedge clk);
        emask = 0; ealive = 0;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 1) emask = emask | (1 << i);
            if (m_st[i] != 0) begin
                ealive++;
                chk($sformatf("x%0d", i), int'(enemy_x[10*i +: 10]), m_x[i]);
                chk($sformatf("y%0d", i), int'(enemy_y[10*i +: 10]), m_y[i]);
            end
        end
        chk("mask", int'(active_mask), emask);
        chk("alive", int'(alive_count), ealive);
        chk("kill", int'(kill_pulse), m_kill);
        chk("escape", int'(escape_pulse), m_esc);
        chk("addr", int'(sprite_addr), pq[$].addr);
        if (pq.size() == 3) begin
            int ergb;
            p = pq.pop_front();
            ergb = (p.cov == 0) ? 'hFFF : ((p.boom != 0) ? 'h969 : rom_f(p.addr));
            chk("rgb", int'(rgb), ergb);
            chk("enemy_en", int'(enemy_en), (p.cov != 0 && ergb != 'hFFF) ? 1 : 0);
            chk("pix_slot", int'(pix_slot), (p.cov != 0) ? p.slot : 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        move_tick = 1'b0; spawn_en = 1'b0; hit_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct { int tk; int sp; int hv; int hi; int mask; int alive; } vec_t;
    vec_t tbl[9];

    initial begin
        int ex;
        int ey;
        int found;
        int ox;

        tbl[0] = '{1, 1, 0, 0, 4'b0001, 1};
        tbl[1] = '{1, 1, 0, 0, 4'b0011, 2};
        tbl[2] = '{1, 1, 0, 0, 4'b0111, 3};
        tbl[3] = '{1, 1, 0, 0, 4'b1111, 4};
        tbl[4] = '{1, 1, 0, 0, 4'b1111, 4};  // all slots busy: no spawn
        tbl[5] = '{0, 0, 1, 1, 4'b1101, 4};  // slot 1 explodes
        tbl[6] = '{1, 0, 1, 1, 4'b1101, 4};  // re-hit during BOOM ignored
        tbl[7] = '{0, 0, 1, 5, 4'b1101, 4};  // out-of-range index ignored
        tbl[8] = '{1, 0, 1, 2, 4'b1001, 4};  // hit beats tick: slot 2 frozen

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            step(tbl[k].tk, tbl[k].sp, tbl[k].hv, tbl[k].hi, 0, 0);
            chk($sformatf("tbl%0d_mask", k), int'(active_mask), tbl[k].mask);
            chk($sformatf("tbl%0d_alive", k), int'(alive_count), tbl[k].alive);
        end
        chk("spawn0_x", int'(enemy_x[9:0]), 'h2A5 - 590);

        // Slot 1 has 30 ticks left, slot 2 has 32.
        repeat (29) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("kill1_pulse", int'(kill_pulse), 1);
        chk("kill1_alive", int'(alive_count), 3);
        step(0, 0, 0, 0, 0, 0);
        chk("kill1_drop", int'(kill_pulse), 0);
        step(1, 0, 0, 0, 0, 0);
        chk("kill2_early", int'(kill_pulse), 0);
        step(1, 0, 0, 0, 0, 0);
        chk("kill2_pulse", int'(kill_pulse), 1);
        chk("kill2_alive", int'(alive_count), 2);

        // Drive slot 0 to the bottom edge.
        for (int k = 0; k < 600 && m_y[0] < 429; k++) step(1, 0, 0, 0, 0, 0);
        chk("y_429", int'(enemy_y[9:0]), 429);
        step(1, 0, 0, 0, 0, 0);
        chk("esc_pulse", int'(escape_pulse), 1);
        chk("esc_mask", int'(active_mask), 4'b1000);
        chk("esc_alive", int'(alive_count), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("esc_drop", int'(escape_pulse), 0);

        // Two explosions ending on the same tick give one single-cycle pulse.
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0);
        repeat (31) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("dkill_pulse", int'(kill_pulse), 1);
        chk("dkill_alive", int'(alive_count), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("dkill_drop", int'(kill_pulse), 0);

        // Pixel pipeline: corners, ROM colour, transparent colour.
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        ex = m_x[0]; ey = m_y[0];
        step(0, 0, 0, 0, ex, ey);
        chk("addr_origin", int'(sprite_addr), 0);
        step(0, 0, 0, 0, ex + 49, ey + 49);
        chk("addr_corner", int'(sprite_addr), 2499);
        step(0, 0, 0, 0, ex + 3, ey);
        chk("rgb_origin", int'(rgb), 'h0F0);
        chk("en_origin", int'(enemy_en), 1);
        step(0, 0, 0, 0, 1000, 1000);
        step(0, 0, 0, 0, 1000, 1000);
        chk("en_transparent", int'(enemy_en), 0);
        chk("rgb_transparent", int'(rgb), 'hFFF);

        // Overlap: wait until the LFSR will place slot 2 near slot 0.
        step(1, 1, 0, 0, 0, 0);
        found = 0;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            ox = fold_x(m_lfsr) - m_x[0];
            if (ox > -30 && ox < 30) found = 1;
            else step(0, 0, 0, 0, 0, 0);
        end
        chk("overlap_found", found, 1);
        step(1, 1, 0, 0, 0, 0);
        ex = (m_x[0] > m_x[2]) ? m_x[0] : m_x[2];
        step(0, 0, 0, 0, ex + 1, 10);
        step(0, 0, 0, 0, 1000, 1000);
        step(0, 0, 0, 0, 1000, 1000);
        chk("overlap_slot", int'(pix_slot), 0);

        // Exploding slot paints BOOM_RGB.
        step(0, 0, 1, 0, 1000, 1000);
        step(0, 0, 0, 0, m_x[0] + 5, m_y[0] + 5);
        step(0, 0, 0, 0, m_x[0] + 5, m_y[0] + 5);
        step(0, 0, 0, 0, m_x[0] + 5, m_y[0] + 5);
        chk("boom_rgb", int'(rgb), 'h969);
        chk("boom_en", int'(enemy_en), 1);

        // Asynchronous reset between edges clears everything at once.
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        model_reset();
        move_tick = 1'b0; spawn_en = 1'b0; hit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            int s;
            if (k == 1500) do_reset();
            s = $urandom_range(0, N - 1);
            step(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? 1 : 0, int'($urandom_range(0, 7)),
                 m_x[s] + int'($urandom_range(0, 69)) - 10,
                 m_y[s] + int'($urandom_range(0, 69)) - 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
